multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control unit for the RV32I core, the successor to the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready-based memory handshake. It drives the same 4-bit ALU encoding, now for I-type as well as R-type, and adds branch/jump control, a memory wait watchdog and a retired-instruction counter. It sits between the instruction register, register file, ALU and the shared memory port.

## Interface
- ALUCTL_W, 4: alu_control width; values above 4 zero-extend the encoding.
- WAIT_MAX, 15: maximum wait cycles for mem_ready before bus_err; range 1..255.
- CNT_W, 32: instret width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  instruction-register output; stable from DECODE to the end of the instruction.
- mem_ready  in  1  memory accepted the access this cycle.
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags: result==0, signed less-than, unsigned less-than.
- ir_we  out  1  latch instr.
- pc_we  out  1  update PC.
- pc_src  out  2  00 pc+4, 01 pc+imm (branch/JAL), 10 ALU result (JALR).
- mem_req, mem_we  out  1 each  memory access request and write enable.
- reg_we  out  1  register file write.
- alu_src_b  out  1  0 rs2, 1 immediate.
- wb_sel  out  2  00 ALU, 01 memory, 10 pc+4.
- alu_control  out  ALUCTL_W  ALU operation code.
- state  out  3  current state, for debug.
- bus_err  out  1  one-cycle pulse on watchdog expiry.
- trap  out  1  illegal instruction, sticky.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - mem_req=1.
  - On mem_ready: ir_we=1 and go to DECODE; otherwise stay.
- DECODE: always goes to EXEC. Illegal opcode goes to TRAP instead (see Configuration).
- EXEC, by opcode:
  - R (0110011), I-ALU (0010011), LUI (0110111), JAL (1101111), JALR (1100111): go to WB.
  - Load (0000011), store (0100011): go to MEM.
  - Branch (1100011): pc_we=1 this cycle, then go to FETCH.
- MEM:
  - mem_req=1; mem_we=1 for store.
  - Store: on mem_ready, pc_we=1 and pc_src=00, then go to FETCH.
  - Load: on mem_ready, go to WB.
- WB:
  - reg_we=1 and pc_we=1, then go to FETCH.
  - wb_sel: 01 for load, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL, 10 for JALR, 00 otherwise.
- alu_control encoding:
  - add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001, pass_b 1010.
- alu_control for R-type: funct3 plus instr[30].
- alu_control for I-ALU:
  - funct3 000 is always add.
  - funct3 101 uses instr[30] to select srl or sra.
- alu_control for other opcodes:
  - Load, store, JALR: add.
  - LUI: pass_b.
  - Branch funct3 000/001: sub.
  - Branch funct3 100/101: slt.
  - Branch funct3 110/111: sltu.
- alu_src_b: 1 for I-ALU, load, store, JALR and LUI; 0 otherwise.
- Branch taken condition:
  - BEQ: alu_zero. BNE: !alu_zero.
  - BLT: alu_lt. BGE: !alu_lt.
  - BLTU: alu_ltu. BGEU: !alu_ltu.
  - pc_src=01 if taken, else 00.
- Watchdog:
  - An 8-bit wait counter increments each cycle in FETCH or MEM while mem_ready=0.
  - It clears on mem_ready or on a state change.
  - On reaching WAIT_MAX: bus_err pulses, the counter clears, mem_req stays asserted and the access retries.
- instret increments in every cycle where pc_we=1 and wraps at 2^CNT_W.

## Timing
- Outputs are combinational from the state register and instr.
- While rst=1: state=FETCH, instret=0, trap=0, wait counter=0, and all outputs are forced to 0, including mem_req.
- mem_req first asserts in the cycle after rst deasserts.
- Latency with zero wait:
  - Branch: 3 cycles.
  - Store, R, I-ALU, LUI, JAL, JALR: 4 cycles.
  - Load: 5 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- pc_we is high for exactly one cycle per retired instruction.
- A mem_ready that arrives in the same cycle as counter==WAIT_MAX wins: no bus_err, and the state advances.
- Asserting rst mid-instruction aborts it immediately; no pc_we and no reg_we are issued.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unlisted opcode in DECODE goes to TRAP. trap=1 and all strobes stay 0 until rst.
- ILLEGAL_TRAP_EN undefined:
  - An unlisted opcode goes DECODE→WB with reg_we=0, executing as a NOP. pc_we=1 with pc_src=00 and instret increments.
  - trap is tied to 0.

## Test plan
- ADD (0x00208033) with mem_ready=1 in FETCH → FETCH→DECODE→EXEC→WB; alu_control=0000, reg_we=1 in cycle 4, instret=1.
- SRAI (0x4020d093) → alu_control=0111, alu_src_b=1. ADDI with instr[30]=1 → alu_control=0000.
- BNE (funct3 001) with alu_zero=0 → EXEC pc_we=1, pc_src=01, 3-cycle instruction. Same with alu_zero=1 → pc_src=00.
- Load with mem_ready held low in MEM for 3 cycles → MEM lasts 4 cycles, then WB with wb_sel=01; total 8 cycles.
- WAIT_MAX=4 with mem_ready=0 in FETCH → bus_err pulses at the 4th wait cycle, mem_req stays 1; mem_ready later → normal DECODE.
- Opcode 0x7F with ILLEGAL_TRAP_EN → state=5, trap=1, instret frozen until rst. Without the macro → NOP, instret+1, reg_we never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait watchdog, retired-instruction counter.
// Define ILLEGAL_TRAP_EN to park unlisted opcodes in a sticky TRAP state; otherwise they retire as NOPs.
module multicycle_controller #(
    parameter int ALUCTL_W = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                alu_zero,
    input  logic                alu_lt,
    input  logic                alu_ltu,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                mem_req,
    output logic                mem_we,
    output logic                reg_we,
    output logic                alu_src_b,
    output logic [1:0]          wb_sel,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [2:0]          state,
    output logic                bus_err,
    output logic                trap,
    output logic [CNT_W-1:0]    instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The watchdog fires on the wait cycle that brings the count of waits up to WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_lui, is_jal, is_jalr, is_load, is_store, is_branch, legal;
    logic        taken;
    logic        src_b_raw;
    logic [3:0]  alu_op;
    logic        in_wait;
    logic        unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_lui    = (opcode == OP_LUI);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign legal     = is_r | is_i | is_lui | is_jal | is_jalr | is_load | is_store | is_branch;
    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? 4'b0001 : 4'b0000;
            3'b001:  arith_op = 4'b0010;
            3'b010:  arith_op = 4'b0011;
            3'b011:  arith_op = 4'b0100;
            3'b100:  arith_op = 4'b0101;
            3'b101:  arith_op = alt ? 4'b0111 : 4'b0110;
            3'b110:  arith_op = 4'b1000;
            default: arith_op = 4'b1001;
        endcase
    endfunction

    always_comb begin
        alu_op    = 4'b0000;
        src_b_raw = is_i | is_load | is_store | is_jalr | is_lui;
        if (is_r) begin
            alu_op = arith_op(funct3, instr[30]);
        end else if (is_i) begin
            // Immediate forms only use instr[30] to tell SRAI from SRLI.
            alu_op = arith_op(funct3, (funct3 == 3'b101) & instr[30]);
        end else if (is_lui) begin
            alu_op = 4'b1010;
        end else if (is_branch) begin
            case (funct3[2:1])
                2'b10:   alu_op = 4'b0011;
                2'b11:   alu_op = 4'b0100;
                default: alu_op = 4'b0001;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_WB;
`endif
                end
            end
            S_EXEC: begin
                if (is_load || is_store) state_d = S_MEM;
                else if (is_branch)      state_d = S_FETCH;
                else                     state_d = S_WB;
            end
            S_MEM:    if (mem_ready) state_d = is_store ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        alu_src_b   = src_b_raw;
        alu_control = ALUCTL_W'(alu_op);
        state       = state_q;
        bus_err     = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
`ifdef ILLEGAL_TRAP_EN
        trap        = (state_q == S_TRAP);
`else
        trap        = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_src = taken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                pc_we   = is_store & mem_ready;
            end
            S_WB: begin
                // Unlisted opcodes reach WB only as NOPs: advance the PC, write nothing.
                pc_we  = 1'b1;
                reg_we = legal;
                if (is_load)              wb_sel = 2'b01;
                else if (is_jal || is_jalr) wb_sel = 2'b10;
                if (is_jal)       pc_src = 2'b01;
                else if (is_jalr) pc_src = 2'b10;
            end
            default: ;
        endcase
        if (rst) begin
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 2'b00;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            reg_we      = 1'b0;
            wb_sel      = 2'b00;
            alu_src_b   = 1'b0;
            alu_control = '0;
            state       = 3'd0;
            bus_err     = 1'b0;
            trap        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (!in_wait || mem_ready || bus_err) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (pc_we) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: drivers queue expected retirements and watchdog pulses, a monitor checks them.
module tb_multicycle_controller;

    localparam int WAIT_MAX = 4;
    localparam int W        = 40;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, alu_zero, alu_lt, alu_ltu;
    logic        ir_we, pc_we, mem_req, mem_we, reg_we, alu_src_b, bus_err, trap;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  alu_control;
    logic [2:0]  state;
    logic [31:0] instret;

    logic [W-1:0] exp_q[$];
    logic [31:0]  err_q[$];
    logic [31:0]  cyc_abs;
    logic         exp_mem_req;
    int           checks;
    int           errors;
    int           retired;

    multicycle_controller #(
        .ALUCTL_W(4),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr(instr),
        .mem_ready(mem_ready),
        .alu_zero(alu_zero),
        .alu_lt(alu_lt),
        .alu_ltu(alu_ltu),
        .ir_we(ir_we),
        .pc_we(pc_we),
        .pc_src(pc_src),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .reg_we(reg_we),
        .alu_src_b(alu_src_b),
        .wb_sel(wb_sel),
        .alu_control(alu_control),
        .state(state),
        .bus_err(bus_err),
        .trap(trap),
        .instret(instret)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc_abs = 32'd0;
    always @(posedge clk) cyc_abs <= cyc_abs + 32'd1;

    initial begin
        #100000;
        $display("FAIL timeout reached without summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp_v, cyc_abs);
        end
    endtask

    // Driver tasks
    task automatic drive_cycle(input logic mr, input logic req, input logic err);
        mem_ready   = mr;
        exp_mem_req = req;
        if (err) err_q.push_back(cyc_abs);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        mem_ready   = 1'b0;
        exp_mem_req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        retired = 0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic lt, input logic ltu,
                             input logic [3:0] e_alu, input logic e_srcb,
                             input logic [1:0] e_pcsrc, input logic [1:0] e_wbsel,
                             input logic e_regwe, input logic e_memwe, input int e_lat);
        logic [6:0] op;
        instr    = ins;
        alu_zero = z;
        alu_lt   = lt;
        alu_ltu  = ltu;
        op       = ins[6:0];
        exp_q.push_back({8'(e_lat), e_regwe, e_memwe, e_wbsel, e_pcsrc, e_srcb, e_alu, 5'd0, 16'(retired)});
        retired++;
        for (int k = 0; k < fw; k++) drive_cycle(1'b0, 1'b1, ((k + 1) % WAIT_MAX) == 0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            drive_cycle(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < mw; k++) drive_cycle(1'b0, 1'b1, ((k + 1) % WAIT_MAX) == 0);
            drive_cycle(1'b1, 1'b1, 1'b0);
            if (op == 7'b0000011) drive_cycle(1'b0, 1'b0, 1'b0);
        end else begin
            for (int k = 0; k < e_lat - fw - 1; k++) drive_cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Scoreboard monitor
    initial begin : monitor
        int           lat;
        logic [W-1:0] p;
        lat = 0;
        forever begin
            @(negedge clk);
            check("mem_req", 64'(mem_req), 64'(exp_mem_req));
            if (rst) begin
                check("reset_outputs", 64'({ir_we, pc_we, pc_src, mem_req, mem_we, reg_we, alu_src_b,
                                            wb_sel, alu_control, state, bus_err, trap, instret}), 64'd0);
                lat = 0;
            end else begin
                lat++;
                if (bus_err) begin
                    if (err_q.size() == 0) check("bus_err_unexpected", 64'd1, 64'd0);
                    else check("bus_err_cycle", 64'(cyc_abs), 64'(err_q.pop_front()));
                end
                if (pc_we) begin
                    if (exp_q.size() == 0) begin
                        check("retire_unexpected", 64'd1, 64'd0);
                    end else begin
                        p = exp_q.pop_front();
                        check("latency",     64'(lat),         64'(p[39:32]));
                        check("reg_we",      64'(reg_we),      64'(p[31]));
                        check("mem_we",      64'(mem_we),      64'(p[30]));
                        check("wb_sel",      64'(wb_sel),      64'(p[29:28]));
                        check("pc_src",      64'(pc_src),      64'(p[27:26]));
                        check("alu_src_b",   64'(alu_src_b),   64'(p[25]));
                        check("alu_control", 64'(alu_control), 64'(p[24:21]));
                        check("instret",     64'(instret),     64'(p[15:0]));
                    end
                    lat = 0;
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        checks      = 0;
        errors      = 0;
        retired     = 0;
        rst         = 1'b1;
        instr       = 32'h4020d093;
        mem_ready   = 1'b0;
        alu_zero    = 1'b0;
        alu_lt      = 1'b0;
        alu_ltu     = 1'b0;
        exp_mem_req = 1'b0;
        do_reset(2);

        // ADD aborted by reset in its WB cycle: nothing retires
        instr = 32'h00208033;
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        do_reset(2);

        //        instr         fw mw  z     lt    ltu   alu      srcb  pcsrc  wbsel  regwe memwe lat
        run_instr(32'h00208033, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h40208033, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h0020c033, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h4020d093, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h40008093, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h0010b093, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h123450b7, 0, 0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4);
        run_instr(32'h008000ef, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 4);
        run_instr(32'h000080e7, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 4);
        run_instr(32'h00209463, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 3);
        run_instr(32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3);
        run_instr(32'h0020e463, 0, 0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 3);
        run_instr(32'h0020d463, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3);
        run_instr(32'h0000a083, 0, 3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 8);
        run_instr(32'h0020a023, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4);
        run_instr(32'h0020a023, 0, 2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 6);
        // Watchdog: expiry in FETCH, mem_ready racing the last wait cycle, expiry in MEM
        run_instr(32'h00208033, 6, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 10);
        run_instr(32'h00208033, 3, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 7);
        run_instr(32'h0000a083, 0, 5, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 10);

`ifdef ILLEGAL_TRAP_EN
        instr = 32'h0000007f;
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("trap_state",   64'(state),   64'd5);
            check("trap_flag",    64'(trap),    64'd1);
            check("trap_instret", 64'(instret), 64'(retired));
            drive_cycle(1'b1, 1'b0, 1'b0);
        end
        do_reset(2);
        run_instr(32'h00208033, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4);
`else
        run_instr(32'h0000007f, 0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3);
        check("trap_tied_low", 64'(trap), 64'd0);
`endif

        drive_cycle(1'b0, 1'b1, 1'b0);
        check("final_instret",   64'(instret),      64'(retired));
        check("retire_q_empty",  64'(exp_q.size()), 64'd0);
        check("bus_err_q_empty", 64'(err_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
